// File: rtl/sdram_line_bridge_pkg.sv
// rtl/sdram_line_bridge_pkg.sv - shared memory-port constants and bridge state type
package sdram_line_bridge_pkg;

    // Cache line size in 32-bit words; the bridge default follows it so both agree.
    localparam int CACHE_LINE_WORDS   = 4;
    localparam int LINE_WORDS_DEFAULT = CACHE_LINE_WORDS;

    // SDRAM controller halfword address width.
    localparam int SDRAM_ADDR_W = 23;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FINISH
    } bridge_state_e;

endpackage

// File: rtl/sdram_line_bridge.sv
// rtl/sdram_line_bridge.sv - cache line fill/write-back to 16-bit SDRAM beat sequencer
//
// Purpose: turns one cache-line read or write request into 2*LINE_WORDS halfword
// SDRAM transactions, low half of each word first, and reports completion with a
// single mem_done pulse. Fill data is assembled into line_read.
//
// Ports:
//   clk, rst_l                  clock, asynchronous active-low reset
//   mem_r_en, mem_w_en          line fill / write-back request levels (write wins)
//   mem_addr                    word address [25:2]; bits [25:24] are ignored
//   line_store, line_read       write-back data in, fill data out (word i at [32i+31:32i])
//   mem_ready, mem_done         idle indication, one-cycle completion pulse
//   SDRAM_ready                 controller can accept a strobe
//   SDRAM_as, SDRAM_rw          one-cycle command strobe, 1 = read / 0 = write
//   SDRAM_addr                  halfword address
//   SDRAM_data_write            write halfword
//   SDRAM_data_read, SDRAM_done read halfword and its one-cycle completion pulse
module sdram_line_bridge
    import sdram_line_bridge_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     mem_r_en,
    input  logic                     mem_w_en,
    input  logic [23:0]              mem_addr,
    input  logic [LINE_WORDS*32-1:0] line_store,
    output logic [LINE_WORDS*32-1:0] line_read,
    output logic                     mem_ready,
    output logic                     mem_done,
    input  logic                     SDRAM_ready,
    output logic                     SDRAM_as,
    output logic                     SDRAM_rw,
    output logic [SDRAM_ADDR_W-1:0]  SDRAM_addr,
    output logic [15:0]              SDRAM_data_write,
    input  logic [15:0]              SDRAM_data_read,
    input  logic                     SDRAM_done
);

    localparam int OW = $clog2(LINE_WORDS);   // word-offset bits within a line
    localparam int BW = OW + 1;               // beat counter bits
    localparam int LB = LINE_WORDS * 32;
    localparam logic [BW-1:0] LAST_BEAT = BW'(2 * LINE_WORDS - 1);

    bridge_state_e           state_q, state_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [21-OW:0]          base_q, base_d;     // line-aligned word address bits [23:2+OW]
    logic                    wr_q, wr_d;
    logic [LB-1:0]           store_q, store_d;
    logic [LB-1:0]           line_q, line_d;
    logic                    as_q, as_d;
    logic [SDRAM_ADDR_W-1:0] addr_q, addr_d;
    logic                    rw_q, rw_d;
    logic [15:0]             wdata_q, wdata_d;
    logic                    load_beat;

    // mem_addr[23:22] are address bits [25:24]; the word offset is replaced by the beat.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[23:22], mem_addr[OW-1:0]};

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        base_d    = base_q;
        wr_d      = wr_q;
        store_d   = store_q;
        line_d    = line_q;
        as_d      = 1'b0;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        load_beat = 1'b0;

        // The strobe is registered: the decision to fire in the next ISSUE cycle is
        // taken from SDRAM_ready at the edge that enters (or stays in) ISSUE.
        unique case (state_q)
            ST_IDLE: begin
                if (mem_w_en || mem_r_en) begin
                    wr_d      = mem_w_en;
                    base_d    = mem_addr[21:OW];
                    store_d   = line_store;
                    beat_d    = '0;
                    state_d   = ST_ISSUE;
                    as_d      = SDRAM_ready;
                    load_beat = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (as_q) begin
                    state_d = ST_WAIT;
                end else begin
                    as_d = SDRAM_ready;
                end
            end
            ST_WAIT: begin
                if (SDRAM_done) begin
                    if (!wr_q) begin
                        line_d[{beat_q, 4'b0000} +: 16] = SDRAM_data_read;
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_FINISH;
                    end else begin
                        beat_d    = beat_q + 1'b1;
                        state_d   = ST_ISSUE;
                        as_d      = SDRAM_ready;
                        load_beat = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Beat b addresses halfword {word, b[0]}; with an aligned base the word is
        // simply the base with the beat's upper bits as offset.
        if (load_beat) begin
            addr_d  = {base_d, beat_d};
            rw_d    = ~wr_d;
            wdata_d = store_d[{beat_d, 4'b0000} +: 16];
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            wr_q    <= 1'b0;
            store_q <= '0;
            line_q  <= '0;
            as_q    <= 1'b0;
            addr_q  <= '0;
            rw_q    <= 1'b1;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            wr_q    <= wr_d;
            store_q <= store_d;
            line_q  <= line_d;
            as_q    <= as_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_ready        = (state_q == ST_IDLE);
    assign mem_done         = (state_q == ST_FINISH);
    assign line_read        = line_q;
    assign SDRAM_as         = as_q;
    assign SDRAM_rw         = rw_q;
    assign SDRAM_addr       = addr_q;
    assign SDRAM_data_write = wdata_q;

endmodule

// File: tb/tb_sdram_line_bridge.sv
// tb/tb_sdram_line_bridge.sv - directed self-checking bench for sdram_line_bridge
module tb_sdram_line_bridge;

    localparam int LW = 4;
    localparam logic [127:0] L1 = 128'h88887777_66665555_44443333_22221111;
    localparam logic [127:0] L3 = 128'h87877878_69695A5A_4B4B3C3C_2D2D1E1E;
    localparam logic [127:0] L5 = 128'h2D2DD2D2_C3C3F0F0_E1E19696_8787B4B4;

    logic           clk = 1'b0;
    logic           rst_l;
    logic           mem_r_en, mem_w_en;
    logic [23:0]    mem_addr;
    logic [LW*32-1:0] line_store, line_read;
    logic           mem_ready, mem_done;
    logic           SDRAM_ready, SDRAM_as, SDRAM_rw;
    logic [22:0]    SDRAM_addr;
    logic [15:0]    SDRAM_data_write;
    logic [15:0]    resp_data;
    logic           resp_done, stray_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sdram_line_bridge #(.LINE_WORDS(LW)) dut (
        .clk              (clk),
        .rst_l            (rst_l),
        .mem_r_en         (mem_r_en),
        .mem_w_en         (mem_w_en),
        .mem_addr         (mem_addr),
        .line_store       (line_store),
        .line_read        (line_read),
        .mem_ready        (mem_ready),
        .mem_done         (mem_done),
        .SDRAM_ready      (SDRAM_ready),
        .SDRAM_as         (SDRAM_as),
        .SDRAM_rw         (SDRAM_rw),
        .SDRAM_addr       (SDRAM_addr),
        .SDRAM_data_write (SDRAM_data_write),
        .SDRAM_data_read  (resp_data),
        .SDRAM_done       (resp_done | stray_done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // SDRAM controller model: logs each strobe, answers resp_d cycles later with a
    // halfword derived from the address, and flags protocol breaches.
    int          resp_d    = 2;
    logic [15:0] salt      = 16'h0000;
    int          proto_err = 0;
    logic [22:0] log_addr[$];
    logic        log_rw[$];
    logic [15:0] log_data[$];
    bit          r_busy = 1'b0;
    int          r_cnt  = 0;
    logic [22:0] r_addr;
    logic        r_rw;
    logic [15:0] r_data;

    initial begin
        resp_done = 1'b0;
        resp_data = 16'h0000;
        forever begin
            @(posedge clk); #1;
            resp_done = 1'b0;
            if (!rst_l) begin
                r_busy = 1'b0;
            end else if (r_busy) begin
                if (SDRAM_as) proto_err++;
                if (SDRAM_addr !== r_addr || SDRAM_rw !== r_rw || SDRAM_data_write !== r_data)
                    proto_err++;
                r_cnt--;
                if (r_cnt == 0) begin
                    resp_done = 1'b1;
                    resp_data = (16'h1111 * (16'(r_addr[2:0]) + 16'd1)) ^ salt;
                    r_busy    = 1'b0;
                end
            end else if (SDRAM_as) begin
                log_addr.push_back(SDRAM_addr);
                log_rw.push_back(SDRAM_rw);
                log_data.push_back(SDRAM_data_write);
                r_addr = SDRAM_addr;
                r_rw   = SDRAM_rw;
                r_data = SDRAM_data_write;
                r_busy = 1'b1;
                r_cnt  = resp_d;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Called in the request cycle (cycle 1); returns the cycle number of mem_done.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!mem_done && cyc < 400) begin
            step();
            cyc++;
        end
        check("done_seen", 128'(mem_done), 128'd1);
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
    endtask

    task automatic check_strobes(input int s, input logic [22:0] base, input logic rw);
        check("strobe_count", 128'(log_addr.size() - s), 128'd8);
        if (log_addr.size() - s == 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("strobe_addr%0d", i), 128'(log_addr[s+i]), 128'(base + 23'(i)));
                check($sformatf("strobe_rw%0d", i), 128'(log_rw[s+i]), 128'(rw));
            end
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ready"}, 128'(mem_ready), 128'd1);
        check({pfx, "_done"},  128'(mem_done),  128'd0);
        check({pfx, "_as"},    128'(SDRAM_as),  128'd0);
        check({pfx, "_rw"},    128'(SDRAM_rw),  128'd1);
        check({pfx, "_addr"},  128'(SDRAM_addr), 128'd0);
        check({pfx, "_wdata"}, 128'(SDRAM_data_write), 128'd0);
        check({pfx, "_line"},  line_read, 128'd0);
    endtask

    logic [15:0] exp_w[8] = '{16'hBEEF, 16'hDEAD, 16'h4567, 16'h0123,
                              16'hCDEF, 16'h89AB, 16'hF00D, 16'hCAFE};

    initial begin
        int s, cyc, k, n, stall_as, stall_moved, ndone, first_done, second_as;

        rst_l = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; mem_addr = '0;
        line_store = '0; SDRAM_ready = 1'b1; stray_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #2 rst_l = 1'b1;
        step();

        // Fill, D=2
        s = log_addr.size(); resp_d = 2; salt = 16'h0000;
        mem_addr = 24'h000013; mem_r_en = 1'b1;
        wait_done(cyc);
        check("fill_latency", 128'(cyc), 128'd26);
        check("fill_line", line_read, L1);
        step();
        check_strobes(s, 23'h000020, 1'b1);

        // Write-back, D=1
        s = log_addr.size(); resp_d = 1;
        line_store = 128'hCAFEF00D_89ABCDEF_01234567_DEADBEEF;
        mem_addr = 24'h000100; mem_w_en = 1'b1;
        wait_done(cyc);
        check("wb_latency", 128'(cyc), 128'd18);
        check("wb_line_kept", line_read, L1);
        step();
        check_strobes(s, 23'h000200, 1'b0);
        if (log_addr.size() - s == 8)
            for (int i = 0; i < 8; i++)
                check($sformatf("wb_data%0d", i), 128'(log_data[s+i]), 128'(exp_w[i]));

        // Fill with SDRAM_ready low for 5 cycles at beat 3
        s = log_addr.size(); resp_d = 1; salt = 16'h0F0F;
        mem_addr = 24'h000040; mem_r_en = 1'b1;
        k = 0;
        while (!(SDRAM_as && SDRAM_addr == 23'h000082) && k < 200) begin
            step(); k++;
        end
        check("stall_beat2_seen", 128'(SDRAM_addr), 128'h82);
        SDRAM_ready = 1'b0;
        stall_as = 0; stall_moved = 0;
        for (int j = 0; j < 5; j++) begin
            step();
            if (SDRAM_as) stall_as++;
            if (j >= 1 && (SDRAM_addr !== 23'h000083 || SDRAM_rw !== 1'b1)) stall_moved++;
            if (j == 4) SDRAM_ready = 1'b1;
        end
        check("stall_no_as", 128'(stall_as), 128'd0);
        check("stall_stable", 128'(stall_moved), 128'd0);
        wait_done(cyc);
        check("stall_line", line_read, L3);
        step();
        check_strobes(s, 23'h000080, 1'b1);

        // Both enables high: write wins, single mem_done
        s = log_addr.size(); resp_d = 1;
        mem_addr = 24'h000008; mem_r_en = 1'b1; mem_w_en = 1'b1;
        wait_done(cyc);
        n = 0;
        repeat (6) begin
            step();
            if (mem_done) n++;
        end
        check("both_extra_done", 128'(n), 128'd0);
        check("both_line_kept", line_read, L3);
        check_strobes(s, 23'h000010, 1'b0);
        if (log_data.size() > s) check("both_data0", 128'(log_data[s]), 128'hBEEF);

        // Reset during WAIT of beat 4
        resp_d = 3; salt = 16'h0000;
        mem_addr = 24'h000030; mem_r_en = 1'b1;
        k = 0;
        while (!(SDRAM_as && SDRAM_addr[2:0] == 3'd4) && k < 200) begin
            step(); k++;
        end
        check("rst_beat4_seen", 128'(SDRAM_addr), 128'h64);
        @(posedge clk); #3;
        rst_l = 1'b0; mem_r_en = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk); #3 rst_l = 1'b1;
        step();
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        check("stray_ready", 128'(mem_ready), 128'd1);
        check("stray_as", 128'(SDRAM_as), 128'd0);
        step();
        check("stray_ready2", 128'(mem_ready), 128'd1);
        check("stray_line", line_read, 128'd0);
        s = log_addr.size(); resp_d = 2; salt = 16'hA5A5;
        mem_r_en = 1'b1;
        wait_done(cyc);
        check("post_rst_latency", 128'(cyc), 128'd26);
        check("post_rst_line", line_read, L5);
        step();
        check_strobes(s, 23'h000060, 1'b1);

        // Back-to-back fills with mem_r_en held through mem_done
        s = log_addr.size(); resp_d = 1; salt = 16'h0000;
        mem_addr = 24'h000020; mem_r_en = 1'b1;
        ndone = 0; cyc = 1; first_done = -1; second_as = -1;
        while (ndone < 2 && cyc < 400) begin
            if (mem_done) begin
                ndone++;
                if (first_done < 0) first_done = cyc;
            end
            if (first_done >= 0 && second_as < 0 && SDRAM_as) second_as = cyc;
            if (second_as >= 0) mem_r_en = 1'b0;
            if (ndone < 2) begin
                step(); cyc++;
            end
        end
        mem_r_en = 1'b0;
        n = 0;
        repeat (5) begin
            step();
            if (mem_done) n++;
        end
        check("b2b_done_count", 128'(ndone), 128'd2);
        check("b2b_restart_gap", 128'(second_as - first_done), 128'd2);
        check("b2b_extra_done", 128'(n), 128'd0);
        check("b2b_strobes", 128'(log_addr.size() - s), 128'd16);
        check("b2b_line", line_read, L1);

        check("protocol", 128'(proto_err), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_line_bridge.md
# sdram_line_bridge

Sits between the cache's line-memory port and the 16-bit SDRAM controller, directly downstream of the cache inside the memory-port manager. It turns one cache-line read (fill) or write (write-back) request into a sequence of 16-bit SDRAM transactions. It assembles fill data into a 32-bit-word line and returns it with a single completion pulse. It owns the SDRAM address strobe and read/write handshake so the cache never sees halfword traffic.

## Interface
Parameters:
- LINE_WORDS, 4: 32-bit words per cache line; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_l  in  1  reset; asynchronous, active-low
- mem_r_en  in  1  line-fill request; level, held until mem_done
- mem_w_en  in  1  line write-back request; level, held until mem_done
- mem_addr  in  24  word address [25:2] of any word in the target line
- line_store  in  LINE_WORDS*32  write-back data; word i at bits [32i+31:32i]
- line_read  out  LINE_WORDS*32  fill data; same packing
- mem_ready  out  1  bridge idle and able to accept a request
- mem_done  out  1  one-cycle completion pulse
- SDRAM_ready  in  1  controller can accept a strobe
- SDRAM_as  out  1  one-cycle address/command strobe
- SDRAM_rw  out  1  1 = read, 0 = write
- SDRAM_addr  out  23  halfword address
- SDRAM_data_write  out  16  write halfword
- SDRAM_data_read  in  16  read halfword; valid only in the SDRAM_done cycle
- SDRAM_done  in  1  one-cycle transaction-complete pulse

## Operation
- States: IDLE, ISSUE, WAIT, FINISH.
- **IDLE:**
  - mem_ready=1.
  - On mem_w_en or mem_r_en: capture the operation (write wins if both are high), the base word address (mem_addr with its low log2(LINE_WORDS) bits cleared), and line_store.
  - Clear the beat counter; go to ISSUE.
- **Beat count and addressing:**
  - 2*LINE_WORDS beats, b = 0..2*LINE_WORDS-1.
  - Word index w = b>>1; half = b[0]. Low half (bits [15:0]) goes first.
  - SDRAM_addr = {(base+w)[23:2], half}. mem_addr[25:24] is ignored.
  - Addresses never wrap across the line; the base is aligned.
- **ISSUE:**
  - Drive SDRAM_addr, SDRAM_rw, and (for writes) SDRAM_data_write for beat b.
  - When SDRAM_ready=1, pulse SDRAM_as for exactly one cycle and go to WAIT.
  - Address, rw, and data stay stable from the strobe cycle until SDRAM_done.
- **WAIT:**
  - On SDRAM_done, a read latches SDRAM_data_read into half `half` of line word w.
  - If b is the last beat, go to FINISH; otherwise increment b and go to ISSUE.
- **FINISH:** mem_done=1 for one cycle; return to IDLE.
- mem_ready=0 in ISSUE, WAIT, and FINISH.
- line_read holds its last fill value until the next fill's first SDRAM_done overwrites it. A write-back never alters line_read.
- A request still high in the IDLE cycle after FINISH starts a new transaction. The requester must drop its enable on seeing mem_done.
- SDRAM_done outside WAIT is ignored.
- **Reset, any state:**
  - Go to IDLE immediately.
  - mem_ready=1, mem_done=0, SDRAM_as=0, SDRAM_rw=1, SDRAM_addr=0, SDRAM_data_write=0, line_read=0, counter=0.
  - An in-flight SDRAM transaction is abandoned; its late SDRAM_done is ignored.

## Timing
- Request sampled in IDLE; ISSUE is entered on the next edge.
- With SDRAM_ready held high, SDRAM_as for beat 0 is asserted in the first ISSUE cycle, one cycle after the request is seen.
- If SDRAM_done arrives D≥1 cycles after SDRAM_as, each beat costs 1+D cycles.
- Line latency, request to mem_done: 1 + 2*LINE_WORDS*(1+D) + 1 cycles.
- SDRAM_as is never asserted on two consecutive cycles and never while a transaction is outstanding.
- All outputs are registered. SDRAM_as, mem_done, and mem_ready are decoded from registered state only, with no combinational path from inputs.

## Structure
- A shared memory package holds:
  - the state enum for IDLE/ISSUE/WAIT/FINISH;
  - LINE_WORDS default, tied to the cache line-size constant so cache and bridge agree;
  - SDRAM_ADDR_W=23.
- No sub-module. One FSM, a beat counter, a line_store capture register, and a line_read assembly register.

## Test plan
- **Fill, ready high, D=2, mem_addr=24'h000013:**
  - Strobes go to halfword addresses 0x000020..0x000027 with rw=1.
  - Return halfwords 0x1111,0x2222,…,0x8888.
  - line_read word0=0x22221111 … word3=0x88887777.
  - mem_done arrives in cycle 1+8*3+1=26.
- **Write-back, line_store words 0xDEADBEEF,0x01234567,0x89ABCDEF,0xCAFEF00D, mem_addr=24'h000100:**
  - Eight writes rw=0 to 0x000200..0x000207.
  - Data in order BEEF,DEAD,4567,0123,CDEF,89AB,F00D,CAFE.
  - line_read unchanged.
- **SDRAM_ready held low 5 cycles at beat 3:** no SDRAM_as during the stall; address, rw, and data stable; completes with correct data afterwards.
- **mem_r_en and mem_w_en both high:** write performed (rw=0 on all 8 strobes); single mem_done.
- **rst_l low during WAIT of beat 4 of a fill:**
  - Outputs take their reset values immediately.
  - A stray SDRAM_done after release causes no state change.
  - A following fill completes normally.
- **Back-to-back:** the requester holds mem_r_en through mem_done; a second full transaction starts the IDLE cycle after FINISH, with mem_done pulsing once per line.
